// File: rtl/fcvt_f_x_pipe_pkg.sv
// rtl/fcvt_f_x_pipe_pkg.sv - shared rounding-mode encodings and exponent bias helper
package fcvt_f_x_pipe_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  function automatic int exp_bias(input int f_exp);
    return (1 << (f_exp - 1)) - 1;
  endfunction

  // Reserved encodings 5-7 fall back to round-to-nearest-even.
  function automatic rm_e rm_decode(input logic [2:0] rm);
    if (rm > 3'd4) return RM_RNE;
    return rm_e'(rm);
  endfunction

endpackage

// File: rtl/fcvt_f_x_pipe_lzc.sv
// rtl/fcvt_f_x_pipe_lzc.sv - parametrised leading-zero counter
module lzc #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]         d,
  output logic [$clog2(WIDTH)-1:0] cnt
);

  localparam int CW = $clog2(WIDTH);

  logic found;

  // An all-zero input reports 0; callers track the zero case separately.
  always_comb begin
    cnt   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && d[i]) begin
        cnt   = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fcvt_f_x_pipe.sv
// rtl/fcvt_f_x_pipe.sv - 3-stage integer to float converter with valid/ready flow control
module fcvt_f_x_pipe
  import fcvt_f_x_pipe_pkg::*;
#(
  parameter int F_WIDTH = 32,
  parameter int F_EXP   = 8,
  parameter int F_FLAC  = 23,
  parameter int I_WIDTH = 64
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [I_WIDTH-1:0] in1,
  input  logic               is_unsigned,
  input  logic               is_word,
  input  logic [2:0]         rm,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [F_WIDTH-1:0] out1,
  output logic               inexact
);

  localparam int BIAS = exp_bias(F_EXP);
  localparam int LZW  = $clog2(I_WIDTH);
  localparam int NW   = I_WIDTH - 1;
  localparam int GPOS = I_WIDTH - 2 - F_FLAC;

  if (I_WIDTH > BIAS) begin : g_chk_range
    $error("I_WIDTH exceeds the exponent range");
  end
  if (F_WIDTH != 1 + F_EXP + F_FLAC) begin : g_chk_fmt
    $error("F_WIDTH must equal 1 + F_EXP + F_FLAC");
  end
  if (GPOS < 1 || I_WIDTH < 32) begin : g_chk_width
    $error("I_WIDTH too narrow for the fraction, guard and sticky bits");
  end

  logic s1_valid, s2_valid, s3_valid;
  logic s3_free, s2_free;

  assign s3_free   = ~s3_valid | out_ready;
  assign s2_free   = ~s2_valid | s3_free;
  assign in_ready  = ~s1_valid | s2_free;
  assign out_valid = s3_valid;

  // S1: select source width, extract sign and magnitude
  logic [I_WIDTH-1:0] fill_c, src_c, abs_c;
  logic               sign_c;

  always_comb begin
    fill_c = {I_WIDTH{~is_unsigned & in1[31]}};
    src_c  = is_word ? ((fill_c << 32) | I_WIDTH'(in1[31:0])) : in1;
    sign_c = ~is_unsigned & src_c[I_WIDTH-1];
    abs_c  = sign_c ? -src_c : src_c;
  end

  logic [I_WIDTH-1:0] s1_abs;
  logic               s1_sign, s1_zero;
  rm_e                s1_rm;

  always_ff @(posedge CLK) begin
    if (in_valid && in_ready) begin
      s1_abs  <= abs_c;
      s1_sign <= sign_c;
      s1_zero <= (abs_c == '0);
      s1_rm   <= rm_decode(rm);
    end
  end

  // S2: normalise so the leading one sits just above the stored bits
  logic [LZW-1:0] lz;

  lzc #(.WIDTH(I_WIDTH)) u_lzc (
    .d   (s1_abs),
    .cnt (lz)
  );

  logic [NW-1:0]    s2_norm;
  logic [F_EXP-1:0] s2_exp;
  logic             s2_sign, s2_zero;
  rm_e              s2_rm;

  always_ff @(posedge CLK) begin
    if (s1_valid && s2_free) begin
      s2_norm <= NW'(s1_abs << lz);
      s2_exp  <= F_EXP'(BIAS + I_WIDTH - 1) - F_EXP'(lz);
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_rm   <= s1_rm;
    end
  end

  // S3: round, pack and flag
  logic [F_FLAC-1:0]  frac_c;
  logic               guard_c, sticky_c, inc_c;
  logic [F_FLAC:0]    sum_c;
  logic [F_EXP-1:0]   exp_r_c;
  logic [F_WIDTH-1:0] pack_c;
  logic               nx_c;

  always_comb begin
    frac_c   = s2_norm[NW-1 -: F_FLAC];
    guard_c  = s2_norm[GPOS];
    sticky_c = |s2_norm[GPOS-1:0];
    case (s2_rm)
      RM_RTZ:  inc_c = 1'b0;
      RM_RDN:  inc_c = s2_sign & (guard_c | sticky_c);
      RM_RUP:  inc_c = ~s2_sign & (guard_c | sticky_c);
      RM_RMM:  inc_c = guard_c;
      default: inc_c = guard_c & (sticky_c | frac_c[0]);
    endcase
    sum_c   = {1'b0, frac_c} + {{F_FLAC{1'b0}}, inc_c};
    exp_r_c = s2_exp + {{(F_EXP-1){1'b0}}, sum_c[F_FLAC]};
    pack_c  = s2_zero ? '0 : {s2_sign, exp_r_c, sum_c[F_FLAC-1:0]};
    nx_c    = ~s2_zero & (guard_c | sticky_c);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      out1     <= '0;
      inexact  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_free)  s2_valid <= s1_valid;
      if (s3_free)  s3_valid <= s2_valid;
      if (s2_valid && s3_free) begin
        out1    <= pack_c;
        inexact <= nx_c;
      end
    end
  end

endmodule

// File: doc/fcvt_f_x_pipe.md
FCVT_F_X_PIPE -- requirements
Module: fcvt_f_x_pipe

Interface
REQ-001 SHALL have parameter F_WIDTH, default 32, float result width.
REQ-002 SHALL have parameter F_EXP, default 8, exponent field width.
REQ-003 SHALL have parameter F_FLAC, default 23, fraction field width.
REQ-004 SHALL have parameter I_WIDTH, default 64, integer source width.
REQ-005 SHALL have port CLK  input  1  clock; all state on rising edge.
REQ-006 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  source operand valid.
REQ-008 SHALL have port in_ready  output  1  block accepts operand this cycle.
REQ-009 SHALL have port in1  input  I_WIDTH  integer operand.
REQ-010 SHALL have port is_unsigned  input  1  treat in1 as unsigned.
REQ-011 SHALL have port is_word  input  1  use only in1[31:0], as signed or unsigned per is_unsigned.
REQ-012 SHALL have port rm  input  3  RISC-V rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
REQ-013 SHALL have port flush  input  1  synchronous kill of all in-flight operations.
REQ-014 SHALL have port out_valid  output  1  result valid.
REQ-015 SHALL have port out_ready  input  1  sink accepts result.
REQ-016 SHALL have port out1  output  F_WIDTH  packed float result {sign, exp, flac}.
REQ-017 SHALL have port inexact  output  1  NX flag for out1, qualified by out_valid.

Function
REQ-018 SHALL be a 3-stage pipeline: S1 sign-extend/abs, S2 leading-one detect and normalise shift, S3 round, pack and flags; latency 3 cycles with no stall.
REQ-019 SHALL accept one operand per cycle when in_valid & in_ready; throughput 1/cycle when out_ready is held high.
REQ-020 SHALL advance each stage when the next stage is empty or advancing; in_ready = ~S1_valid | S1_advance.
REQ-021 SHALL hold out1/inexact stable while out_valid & ~out_ready.
REQ-022 SHALL set sign = 0 when is_unsigned, else the MSB of the selected source (bit 31 when is_word, bit I_WIDTH-1 otherwise).
REQ-023 SHALL compute exp = (2^(F_EXP-1)-1) + (I_WIDTH-1-lz), where lz is the leading-zero count of abs.
REQ-024 SHALL take guard = bit F_FLAC+1 below the leading one, and sticky = OR of all lower bits.
REQ-025 SHALL increment the fraction: RNE G&(S|L); RTZ never; RDN sign&(G|S); RUP ~sign&(G|S); RMM G. L is the fraction LSB.
REQ-026 SHALL add one to exp and zero flac when rounding carries out of the fraction.
REQ-027 SHALL treat rm values 5-7 as RNE.
REQ-028 SHALL produce out1 = all-zeros and inexact = 0 for a zero operand in every mode.
REQ-029 SHALL set inexact = G|S for nonzero operands.
REQ-030 SHALL carry rm, sign and zero tag with the operand through all stages; per-operation modes SHALL never mix.
REQ-031 SHALL clear all stage valids on flush and ignore in_valid in that cycle; out_valid SHALL be 0 the next cycle.
REQ-032 SHALL require I_WIDTH <= 2^(F_EXP-1)-1 (elaboration check), so overflow cannot occur.

Reset
REQ-033 SHALL, on RSTn low, asynchronously clear all stage valids: out_valid = 0, out1 = 0, inexact = 0, in_ready = 1 after release.
REQ-034 SHALL discard in-flight operations when reset is asserted mid-operation; no result SHALL appear after release.

Structure
REQ-035 SHALL take rounding-mode encodings and bias computation from the shared defs package/header.
REQ-036 SHALL instantiate one sub-module, lzc (parametrised leading-zero counter), in S2.

Verification
REQ-037 Bench SHALL cover: in1 = 1, then 0xFFFFFFFFFFFFFFFF signed, RNE -> 0x3F800000, then 0xBF800000, NX = 0.
REQ-038 Bench SHALL cover: in1 = 0x1000001: RNE -> 0x4B800000, NX = 1; RUP -> 0x4B800001; RMM -> 0x4B800001; RTZ -> 0x4B800000.
REQ-039 Bench SHALL cover: in1 = 0x8000000000000000 signed -> 0xDF000000, NX = 0; same input unsigned -> 0x5F000000.
REQ-040 Bench SHALL cover: 0xFFFFFFFFFFFFFFFF unsigned: RNE -> 0x5F800000, NX = 1; RTZ -> 0x5F7FFFFF; is_word signed with low word 0xFFFFFFFF -> 0xBF800000.
REQ-041 Bench SHALL cover: 8 back-to-back operands with out_ready toggling randomly -> all 8 results in order, none lost or duplicated, in_ready low only while full.
REQ-042 Bench SHALL cover: flush, and separately RSTn low, with 3 operations in flight -> no out_valid for those operations; next operand returns a correct result after 3 cycles.
